// File: rtl/miss_arbiter.sv
// miss_arbiter: serialises I-cache and D-cache misses onto one main-memory port,
// one outstanding request at a time. A dirty D victim is written back before its refill.
// I is forced in after STARVE_LIM consecutive D grants made while I was waiting.
// Optional statistics counters are built when MISS_ARB_STATS_EN is defined.
module miss_arbiter #(
  parameter int LINE_ADDR_W = 14,
  parameter int LINE_W      = 64,
  parameter int STARVE_LIM  = 4
`ifdef MISS_ARB_STATS_EN
  ,
  parameter int CNT_W       = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_miss,
  input  logic [LINE_ADDR_W-1:0] i_miss_addr,
  output logic                   i_fill_we,
  output logic [LINE_W-1:0]      i_fill_line,
  output logic                   i_stall,
  input  logic                   d_miss,
  input  logic [LINE_ADDR_W-1:0] d_miss_addr,
  input  logic                   d_dirty,
  input  logic [LINE_ADDR_W-1:0] d_evict_addr,
  input  logic [LINE_W-1:0]      d_evict_line,
  output logic                   d_fill_we,
  output logic [LINE_W-1:0]      d_fill_line,
  output logic                   d_stall,
  output logic                   mem_re,
  output logic                   mem_we,
  output logic [LINE_ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]      mem_wdata,
  input  logic [LINE_W-1:0]      mem_rdata,
  input  logic                   mem_rdy
`ifdef MISS_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]       i_miss_cnt,
  output logic [CNT_W-1:0]       d_miss_cnt,
  output logic [CNT_W-1:0]       wb_cnt
`endif
);

  localparam int STARVE_W = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_WB   = 2'd1,
    D_FILL = 2'd2,
    I_FILL = 2'd3
  } state_t;

  state_t                 state;
  state_t                 nextState;
  logic [STARVE_W-1:0]    starveCnt;
  logic [STARVE_W-1:0]    starveNext;
  logic [LINE_ADDR_W-1:0] missAddr;
  logic [LINE_ADDR_W-1:0] evictAddr;
  logic [LINE_W-1:0]      evictLine;
  logic                   grantD;
  logic                   grantI;
  logic                   starveHit;

  // Grant decision in IDLE and next-state / starvation-count update
  always_comb begin
    nextState  = state;
    starveNext = starveCnt;
    starveHit  = (starveCnt >= STARVE_W'(STARVE_LIM));
    grantD     = (state == IDLE) && d_miss && (!i_miss || !starveHit);
    grantI     = (state == IDLE) && !grantD && i_miss;

    case (state)
      IDLE: begin
        if (grantD) begin
          nextState = d_dirty ? D_WB : D_FILL;
        end else if (grantI) begin
          nextState = I_FILL;
        end
      end
      D_WB:    if (mem_rdy) nextState = D_FILL;
      D_FILL:  if (mem_rdy) nextState = IDLE;
      I_FILL:  if (mem_rdy) nextState = IDLE;
      default: nextState = IDLE;
    endcase

    // I grant or an idle cycle with no I miss ends the starvation run
    if (grantI || ((state == IDLE) && !i_miss)) begin
      starveNext = '0;
    end else if (grantD && i_miss && !starveHit) begin
      starveNext = starveCnt + STARVE_W'(1);
    end
  end

  // State, starvation counter and the addresses/data latched at grant time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      starveCnt <= '0;
      missAddr  <= '0;
      evictAddr <= '0;
      evictLine <= '0;
    end else begin
      state     <= nextState;
      starveCnt <= starveNext;
      if (grantD) begin
        missAddr <= d_miss_addr;
        if (d_dirty) begin
          evictAddr <= d_evict_addr;
          evictLine <= d_evict_line;
        end
      end else if (grantI) begin
        missAddr <= i_miss_addr;
      end
    end
  end

  // Memory port, fill strobes and stalls decoded from the current state
  always_comb begin
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_line = '0;
    d_fill_line = '0;

    case (state)
      D_WB: begin
        mem_we    = 1'b1;
        mem_addr  = evictAddr;
        mem_wdata = evictLine;
      end
      D_FILL: begin
        mem_re   = 1'b1;
        mem_addr = missAddr;
        if (mem_rdy) begin
          d_fill_we   = 1'b1;
          d_fill_line = mem_rdata;
        end
      end
      I_FILL: begin
        mem_re   = 1'b1;
        mem_addr = missAddr;
        if (mem_rdy) begin
          i_fill_we   = 1'b1;
          i_fill_line = mem_rdata;
        end
      end
      default: ;
    endcase

    // Stalls follow the raw miss inputs, so they are forced low while reset is held
    i_stall = !rst && (i_miss || (state == I_FILL));
    d_stall = !rst && (d_miss || (state == D_WB) || (state == D_FILL));
  end

`ifdef MISS_ARB_STATS_EN
  logic wbDone;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign wbDone = (state == D_WB) && mem_rdy;

  // Saturating grant and writeback statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_miss_cnt <= '0;
      d_miss_cnt <= '0;
      wb_cnt     <= '0;
    end else begin
      if (grantI) i_miss_cnt <= satInc(i_miss_cnt);
      if (grantD) d_miss_cnt <= satInc(d_miss_cnt);
      if (wbDone) wb_cnt     <= satInc(wb_cnt);
    end
  end
`endif

endmodule
